// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: picks when, where and what obstacle spawns into the slot pool
// on each frame tick, enforcing clear time, spacing, pterodactyl speed and duplicate limits.
module obstacle_scheduler #(
   parameter int N_SLOTS         = 3,
   parameter int CLEAR_TICKS     = 180,
   parameter int MAX_DUP         = 2,
   parameter int PTERO_MIN_SPEED = 8704,
   parameter int GAME_WIDTH      = 640
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   update,
   input  logic                   game_start,
   input  logic                   crash,
   input  logic [14:0]            speed,
   input  logic [10:0]            rng_data,
   input  logic [N_SLOTS-1:0]     slot_remove,
   input  logic [N_SLOTS*11-1:0]  slot_x_pos,
   input  logic [N_SLOTS*10-1:0]  slot_width,
   input  logic [N_SLOTS*11-1:0]  slot_gap,
   output logic [N_SLOTS-1:0]     slot_start,
   output logic [N_SLOTS*3-1:0]   slot_typ,
   output logic [1:0]             sched_state,
   output logic [15:0]            spawn_count
);
   localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, CLEARING = 2'd1, RUNNING = 2'd2, CRASHED = 2'd3} state_t;
   typedef enum logic [2:0] {NONE = 3'd0, CACTUS_SMALL = 3'd1, CACTUS_LARGE = 3'd2, PTERODACTYL = 3'd3} type_t;

   state_t               state, state_n;
   type_t                last_type, last_type_n, cand, chosen;
   logic [15:0]          clear_cnt, clear_cnt_n, cnt_inc, spawn_count_n;
   logic [N_SLOTS-1:0]   busy, busy_n, hold, hold_n, slot_start_n, free, busy_eff, pick;
   logic [N_SLOTS*3-1:0] slot_typ_n;
   logic [3:0]           dup_count, dup_count_n;
   logic [SW-1:0]        last_slot, last_slot_n, sel;
   logic                 has_free, spacing_ok, reject, spawn;
   logic [10:0]          lx, lg;
   logic [9:0]           lw;
   logic [12:0]          reach;
   logic                 unused_rng;

   assign unused_rng  = ^rng_data[10:2];
   assign sched_state = state;

   always_comb begin
      free     = (~busy | slot_remove) & ~hold;
      busy_eff = busy & ~(slot_remove & ~hold);
      has_free = 1'b0;
      sel      = '0;
      lx       = '0;
      lw       = '0;
      lg       = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (free[i]) begin
            has_free = 1'b1;
            sel      = SW'(i);
         end
      end
      for (int i = 0; i < N_SLOTS; i++) begin
         if (SW'(i) == last_slot) begin
            lx = slot_x_pos[11*i +: 11];
            lw = slot_width[10*i +: 10];
            lg = slot_gap[11*i +: 11];
         end
      end
      pick = '0;
      for (int i = 0; i < N_SLOTS; i++) pick[i] = has_free && (SW'(i) == sel);
      // x_pos is signed (obstacles scroll off the left edge), width and gap are not
      reach      = {{2{lx[10]}}, lx} + {3'b000, lw} + {2'b00, lg};
      spacing_ok = (busy_eff == '0) || ($signed(reach) < $signed(13'(GAME_WIDTH)));
      spawn      = has_free && spacing_ok;
      cand       = (rng_data[1:0] == 2'd1) ? CACTUS_LARGE :
                   (rng_data[1:0] == 2'd2) ? PTERODACTYL : CACTUS_SMALL;
      reject     = (cand == PTERODACTYL && speed < 15'(PTERO_MIN_SPEED)) ||
                   (cand == last_type && dup_count >= 4'(MAX_DUP));
      chosen     = reject ? ((last_type == CACTUS_SMALL) ? CACTUS_LARGE : CACTUS_SMALL) : cand;
      cnt_inc    = clear_cnt + 16'd1;
      state_n       = state;
      clear_cnt_n   = clear_cnt;
      busy_n        = busy;
      hold_n        = hold;
      slot_start_n  = slot_start;
      slot_typ_n    = slot_typ;
      spawn_count_n = spawn_count;
      last_type_n   = last_type;
      dup_count_n   = dup_count;
      last_slot_n   = last_slot;
      if (update) begin
         slot_start_n = '0;
         hold_n       = '0;
         if (crash) state_n = CRASHED;
         else if (state == IDLE) state_n = game_start ? CLEARING : IDLE;
         else if (state == CLEARING) begin
            clear_cnt_n = cnt_inc;
            state_n     = (cnt_inc == 16'(CLEAR_TICKS - 1)) ? RUNNING : CLEARING;
         end else if (state == RUNNING) begin
            busy_n = busy_eff;
            if (spawn) begin
               busy_n        = busy_eff | pick;
               hold_n        = pick;
               slot_start_n  = pick;
               last_type_n   = chosen;
               dup_count_n   = (chosen == last_type) ? dup_count + 4'd1 : 4'd1;
               last_slot_n   = sel;
               spawn_count_n = (spawn_count == 16'hFFFF) ? spawn_count : spawn_count + 16'd1;
               for (int i = 0; i < N_SLOTS; i++) begin
                  if (pick[i]) slot_typ_n[3*i +: 3] = chosen;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         clear_cnt   <= '0;
         busy        <= '0;
         hold        <= '0;
         slot_start  <= '0;
         slot_typ    <= '0;
         spawn_count <= '0;
         last_type   <= NONE;
         dup_count   <= '0;
         last_slot   <= '0;
      end else begin
         state       <= state_n;
         clear_cnt   <= clear_cnt_n;
         busy        <= busy_n;
         hold        <= hold_n;
         slot_start  <= slot_start_n;
         slot_typ    <= slot_typ_n;
         spawn_count <= spawn_count_n;
         last_type   <= last_type_n;
         dup_count   <= dup_count_n;
         last_slot   <= last_slot_n;
      end
   end
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: directed scenarios for obstacle_scheduler with hand-computed expectations.
module tb_obstacle_scheduler;
   localparam logic [2:0] SMALL = 3'd1, LARGE = 3'd2, PTERO = 3'd3;

   logic        clk = 1'b0;
   logic        rst, update, game_start, crash;
   logic [14:0] speed;
   logic [10:0] rng_data;
   logic [2:0]  slot_remove, slot_start;
   logic [32:0] slot_x_pos, slot_gap;
   logic [29:0] slot_width;
   logic [8:0]  slot_typ;
   logic [1:0]  sched_state;
   logic [15:0] spawn_count;
   int total = 0;
   int bad = 0;

   obstacle_scheduler dut (
      .clk(clk), .rst(rst), .update(update), .game_start(game_start), .crash(crash),
      .speed(speed), .rng_data(rng_data), .slot_remove(slot_remove), .slot_x_pos(slot_x_pos),
      .slot_width(slot_width), .slot_gap(slot_gap), .slot_start(slot_start), .slot_typ(slot_typ),
      .sched_state(sched_state), .spawn_count(spawn_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
   endtask

   task automatic set_slot(input int i, input logic [10:0] x, input logic [9:0] w, input logic [10:0] g);
      slot_x_pos[11*i +: 11] = x;
      slot_width[10*i +: 10] = w;
      slot_gap[11*i +: 11]   = g;
   endtask

   task automatic run_clearing();
      for (int t = 1; t <= 180; t++) begin
         tick();
         total++;
         if (slot_start !== 3'b000) begin bad++; $display("FAIL clear_start t=%0d got=%b exp=000", t, slot_start); end
         if (t == 1) begin
            total++;
            if (sched_state !== 2'd1) begin bad++; $display("FAIL clear_state got=%0d exp=1", sched_state); end
         end
      end
      total++;
      if (sched_state !== 2'd2) begin bad++; $display("FAIL running_state got=%0d exp=2", sched_state); end
   endtask

   task automatic test_reset();
      rst = 1'b0; update = 1'b0; game_start = 1'b0; crash = 1'b0; speed = '0; rng_data = '0;
      slot_remove = '0; slot_x_pos = '0; slot_width = '0; slot_gap = '0;
      repeat (2) @(negedge clk);
      total++;
      if (sched_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", sched_state); end
      total++;
      if ({slot_start, slot_typ, spawn_count} !== '0) begin bad++; $display("FAIL reset_outputs start=%b typ=%h count=%0d exp=0", slot_start, slot_typ, spawn_count); end
      rst = 1'b1;
      tick();
      total++;
      if (sched_state !== 2'd0) begin bad++; $display("FAIL idle_hold got=%0d exp=0", sched_state); end
   endtask

   task automatic test_clearing();
      game_start = 1'b1; speed = 15'd9000; rng_data = 11'd0;
      set_slot(0, 11'd600, 10'd17, 11'd130);
      run_clearing();
      tick();
      total++;
      if (slot_start !== 3'b001) begin bad++; $display("FAIL first_start got=%b exp=001", slot_start); end
      total++;
      if (slot_typ !== {6'd0, SMALL}) begin bad++; $display("FAIL first_typ got=%h exp=%h", slot_typ, {6'd0, SMALL}); end
      total++;
      if (spawn_count !== 16'd1) begin bad++; $display("FAIL first_count got=%0d exp=1", spawn_count); end
      @(negedge clk);
      total++;
      if (slot_start !== 3'b001) begin bad++; $display("FAIL start_between got=%b exp=001", slot_start); end
      tick();
      total++;
      if (slot_start !== 3'b000) begin bad++; $display("FAIL start_drop got=%b exp=000", slot_start); end
   endtask

   task automatic test_spacing_type();
      set_slot(0, 11'd493, 10'd17, 11'd130);
      rng_data = 11'd2; speed = 15'd8000;
      tick();
      total++;
      if (slot_start !== 3'b000) begin bad++; $display("FAIL gap_493 got=%b exp=000", slot_start); end
      set_slot(0, 11'd492, 10'd17, 11'd130);
      tick();
      total++;
      if (slot_start !== 3'b010) begin bad++; $display("FAIL gap_492 got=%b exp=010", slot_start); end
      total++;
      if (slot_typ[5:3] !== LARGE) begin bad++; $display("FAIL slow_ptero got=%0d exp=%0d", slot_typ[5:3], LARGE); end
      set_slot(1, 11'd600, 10'd17, 11'd130);
      tick();
      total++;
      if (slot_start !== 3'b000) begin bad++; $display("FAIL gap_last_slot got=%b exp=000", slot_start); end
      set_slot(1, 11'd100, 10'd17, 11'd130);
      speed = 15'd9000;
      tick();
      total++;
      if (slot_start !== 3'b100) begin bad++; $display("FAIL fast_ptero_slot got=%b exp=100", slot_start); end
      total++;
      if (slot_typ[8:6] !== PTERO) begin bad++; $display("FAIL fast_ptero got=%0d exp=%0d", slot_typ[8:6], PTERO); end
      total++;
      if (spawn_count !== 16'd3) begin bad++; $display("FAIL count_3 got=%0d exp=3", spawn_count); end
   endtask

   task automatic test_dup();
      rng_data = 11'd1;
      slot_remove = 3'b001;
      tick();
      total++;
      if (slot_start !== 3'b001 || slot_typ[2:0] !== LARGE) begin bad++; $display("FAIL dup_1 start=%b typ=%0d exp=001/%0d", slot_start, slot_typ[2:0], LARGE); end
      slot_remove = 3'b011;
      tick();
      total++;
      if (slot_start !== 3'b010 || slot_typ[5:3] !== LARGE) begin bad++; $display("FAIL dup_2 start=%b typ=%0d exp=010/%0d", slot_start, slot_typ[5:3], LARGE); end
      slot_remove = 3'b110;
      tick();
      total++;
      if (slot_start !== 3'b100 || slot_typ[8:6] !== SMALL) begin bad++; $display("FAIL dup_3 start=%b typ=%0d exp=100/%0d", slot_start, slot_typ[8:6], SMALL); end
      total++;
      if (spawn_count !== 16'd6) begin bad++; $display("FAIL count_6 got=%0d exp=6", spawn_count); end
   endtask

   task automatic test_back_to_back();
      slot_remove = 3'b000; rng_data = 11'd0;
      repeat (2) begin
         tick();
         total++;
         if (slot_start !== 3'b000) begin bad++; $display("FAIL all_busy got=%b exp=000", slot_start); end
      end
      slot_remove = 3'b010;
      tick();
      total++;
      if (slot_start !== 3'b010 || slot_typ[5:3] !== SMALL) begin bad++; $display("FAIL refill start=%b typ=%0d exp=010/%0d", slot_start, slot_typ[5:3], SMALL); end
      tick();
      total++;
      if (slot_start !== 3'b000) begin bad++; $display("FAIL hold_mask got=%b exp=000", slot_start); end
      total++;
      if (spawn_count !== 16'd7) begin bad++; $display("FAIL count_7 got=%0d exp=7", spawn_count); end
   endtask

   task automatic test_crash();
      slot_remove = 3'b001; rng_data = 11'd1;
      tick();
      total++;
      if (slot_start !== 3'b001 || spawn_count !== 16'd8) begin bad++; $display("FAIL pre_crash start=%b count=%0d exp=001/8", slot_start, spawn_count); end
      crash = 1'b1; game_start = 1'b1;
      tick();
      total++;
      if (sched_state !== 2'd3 || slot_start !== 3'b000) begin bad++; $display("FAIL crash state=%0d start=%b exp=3/000", sched_state, slot_start); end
      total++;
      if (slot_typ[2:0] !== LARGE || spawn_count !== 16'd8) begin bad++; $display("FAIL crash_hold typ=%0d count=%0d exp=%0d/8", slot_typ[2:0], spawn_count, LARGE); end
      crash = 1'b0;
      repeat (3) tick();
      total++;
      if (sched_state !== 2'd3 || slot_start !== 3'b000 || spawn_count !== 16'd8) begin bad++; $display("FAIL crash_terminal state=%0d start=%b count=%0d exp=3/000/8", sched_state, slot_start, spawn_count); end
   endtask

   task automatic test_async_reset();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1; crash = 1'b0; game_start = 1'b1; slot_remove = 3'b000; rng_data = 11'd0;
      set_slot(0, 11'd600, 10'd17, 11'd130);
      run_clearing();
      tick();
      total++;
      if (slot_start !== 3'b001) begin bad++; $display("FAIL rerun_start got=%b exp=001", slot_start); end
      #2 rst = 1'b0;
      #1;
      total++;
      if (sched_state !== 2'd0 || {slot_start, slot_typ, spawn_count} !== '0) begin bad++; $display("FAIL async_reset state=%0d start=%b typ=%h count=%0d exp=0", sched_state, slot_start, slot_typ, spawn_count); end
      @(negedge clk);
      rst = 1'b1; game_start = 1'b0;
      repeat (2) tick();
      total++;
      if (sched_state !== 2'd0) begin bad++; $display("FAIL post_reset_idle got=%0d exp=0", sched_state); end
      game_start = 1'b1;
      tick();
      total++;
      if (sched_state !== 2'd1) begin bad++; $display("FAIL restart got=%0d exp=1", sched_state); end
   endtask

   initial begin
      test_reset();
      test_clearing();
      test_spacing_type();
      test_dup();
      test_back_to_back();
      test_crash();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
